alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle ALU, the successor to the team's combinational 32-bit ALU. It keeps the same 3-bit opcode set and adds:
- registered outputs;
- a start/busy/done handshake;
- carry and overflow flags;
- an iterative shift-add multiplier instead of a combinational one.

It sits between the datapath register file and the result writeback stage. The controller issues one operation at a time and waits for `done`.

## Interface
Parameters:
- `WIDTH`, default 32. Operand and result width; legal range 4..64.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an operation; sampled only while `busy`=0.
- `op` in 3: opcode, sampled with `start`.
- `a` in WIDTH: operand A, sampled with `start`.
- `b` in WIDTH: operand B, sampled with `start`.
- `busy` out 1: high while a multiply is iterating.
- `done` out 1: one-cycle pulse; `r`/`z`/`c`/`v` are valid from this cycle on.
- `r` out WIDTH: result register.
- `z` out 1: result is zero.
- `c` out 1: carry/no-borrow flag.
- `v` out 1: signed overflow flag.

## Operation
Opcodes:
- 000: r=0.
- 001: r=a+b. c = carry out of bit WIDTH-1; v = signed overflow.
- 010: r=a&b.
- 011: r=a|b.
- 100: r = low WIDTH bits of a*b (unsigned; the upper half is discarded).
- 101: r=a-b. c=1 when a>=b unsigned (no borrow); v = signed overflow.
- 110: r = (a<b unsigned) ? 1 : 0.
- 111: r = (a<b signed) ? 1 : 0.

Flag rules:
- c and v are 0 for every op other than 001 and 101.
- z = (r==0) for all ops, updated together with r.

FSM states:
- IDLE:
  - `start`=1 with a non-multiply op: compute and register r/z/c/v, pulse `done`, stay in IDLE.
  - `start`=1 with op=100: latch a into A_SH and b into B_SH, clear ACC, load CNT=WIDTH, set `busy`, go to MUL.
- MUL, once per edge:
  - if B_SH[0], ACC += A_SH (mod 2^WIDTH);
  - A_SH <<= 1; B_SH >>= 1; CNT -= 1.
  - When the terminating iteration is performed (CNT reaches 0), write r = the updated ACC, write z, set c=v=0, pulse `done`, clear `busy`, return to IDLE.

Handshake rules:
- `start` while `busy`=1 is ignored. It is not queued, and `op`/`a`/`b` changes have no effect.
- `start` in the same cycle as `done` is accepted, because `busy` is already 0.
- r/z/c/v hold their value between operations; only a completed operation or `rst` changes them.

Reset:
- Reset values: r=0, z=1, c=0, v=0, busy=0, done=0, state=IDLE.
- `rst` during MUL aborts the multiply. No `done` is produced, outputs take their reset values, and `start` in the same cycle as `rst` is dropped.

## Timing
- Let E be the edge that samples `start`.
- Non-multiply ops: r/z/c/v and `done`=1 are visible in the cycle after E. Latency is 1 cycle, giving 1 result per cycle back to back.
- Multiply: `busy`=1 from the cycle after E. The iterations occur at edges E+1..E+N. `done`=1 and r are visible after edge E+N, where N=WIDTH by default (see Configuration).
- Throughput with no early exit: one multiply per N+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_MUL_EARLY_EXIT_EN` defined:
  - MUL terminates at the first iteration after which B_SH==0, so N = max(1, index of the highest set bit of b + 1).
  - b=0 therefore completes in N=1 with r=0.
  - The result is identical to the non-early-exit result; only latency changes.
- Not defined: N is always WIDTH, which gives fixed, data-independent latency.

## Test plan
- Reset, then idle: r=0, z=1, c=v=busy=done=0. Then at WIDTH=32, op=001, a=0xFFFFFFFF, b=1: one cycle later r=0, z=1, c=1, v=0, done pulses once.
- op=101 with a=0x80000000, b=1: r=0x7FFFFFFF, c=1, v=1. Back-to-back op=110 with a=1, b=0x80000000: r=1. Then op=111 with the same operands: r=0, z=1.
- op=100 with a=0x0001_0003, b=0x0000_0005:
  - without the macro, busy is high for 32 cycles, then done with r=0x0005_000F;
  - with the macro, N=3.
- During a multiply, pulse `start` with op=010: the request is ignored, the multiply result is unchanged, and exactly one `done` appears. Then pulse `start` in the `done` cycle with op=011, a=0xF0, b=0x0F: the next cycle gives r=0xFF.
- Assert `rst` at iteration 10 of a multiply: no `done`, outputs return to their reset values, and a new op=001 with a=2, b=3 completes with r=5.
- WIDTH=8, op=100, a=0xFF, b=0xFF: r=0x01 after 8 iterations (or 8 with the macro, since bit 7 is set). op=001 with a=0x7F, b=1: r=0x80, v=1, c=0.

Source files
------------

// File: rtl/alu_mc_if.sv
// ============================================================================
//  Module      : alu_mc_if
//  Description : Start/busy/done request bus and result/flag bus for alu_mc.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             z;
    logic             c;
    logic             v;

    modport master (output start, op, a, b, input  busy, done, r, z, c, v);
    modport slave  (input  start, op, a, b, output busy, done, r, z, c, v);
endinterface

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle ALU with registered flags and an iterative
//                shift-add multiplier. Define ALU_MUL_EARLY_EXIT_EN to end
//                multiplies as soon as the remaining multiplier bits are zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_mc #(
    parameter int WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_mc_if.slave    bus
);
    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_cnt_one = CW'(1);
    localparam logic [CW-1:0]  c_cnt_max = CW'(WIDTH);
    localparam logic [2:0]     c_op_mul  = 3'b100;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_z;
    logic             r_c;
    logic             r_v;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_last;

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = bus.a - bus.b;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.op)
            3'b001: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b010: w_res = bus.a & bus.b;
            3'b011: w_res = bus.a | bus.b;
            3'b101: begin
                w_res = w_diff;
                w_c   = (bus.a >= bus.b);
                w_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b110: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            3'b111: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: w_res = '0;
        endcase
    end

    assign w_acc_next = r_b_sh[0] ? (r_acc + r_a_sh) : r_acc;

`ifdef ALU_MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all zero after this shift: nothing left to add.
    assign w_mul_last = (r_cnt == c_cnt_one) || (r_b_sh[WIDTH-1:1] == '0);
`else
    assign w_mul_last = (r_cnt == c_cnt_one);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_z     <= 1'b1;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == c_op_mul) begin
                            r_a_sh  <= bus.a;
                            r_b_sh  <= bus.b;
                            r_acc   <= '0;
                            r_cnt   <= c_cnt_max;
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
                        end else begin
                            r_res  <= w_res;
                            r_z    <= (w_res == '0);
                            r_c    <= w_c;
                            r_v    <= w_v;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt - c_cnt_one;
                    if (w_mul_last) begin
                        r_res   <= w_acc_next;
                        r_z     <= (w_acc_next == '0);
                        r_c     <= 1'b0;
                        r_v     <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.r    = r_res;
    assign bus.z    = r_z;
    assign bus.c    = r_c;
    assign bus.v    = r_v;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

`default_nettype wire
